// File: rtl/key_debouncer.sv
// key_debouncer: synchronises active-low push-buttons into CLOCK_50 and
// rejects contact bounce with a per-key stability counter.
//
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   Reset       in   synchronous active-high reset
//   KEY         in   raw asynchronous keys, active-low (0 = pressed)
//   Key_Down    out  debounced pressed level, active-high
//   Key_Press   out  one-cycle strobe per accepted press (and per repeat)
//   Key_Release out  one-cycle strobe per accepted release
//
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat Key_Press
// strobes while a key stays held (HOLD_CYCLES first delay, REPEAT_CYCLES
// period). Undefined: one Key_Press per press, no hold-counter logic.

module key_debouncer #(
  parameter int unsigned NUM_KEYS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] Key_Down,
  output logic [NUM_KEYS-1:0] Key_Press,
  output logic [NUM_KEYS-1:0] Key_Release
);

  localparam int unsigned MAX_DH     = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } key_state_t;

  // Two-flop synchroniser; preset to released so reset never looks like a press
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             down_q, down_nxt;
    logic             press_q, press_nxt;
    logic             release_q, release_nxt;
    logic             sample;
    logic             repeat_fire_c;

    assign sample = ~sync2[k];

`ifdef KEY_REPEAT_EN
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             repeating, repeating_nxt;

    // Hold timer: runs only while HELD with the key still down; first fire
    // after HOLD_CYCLES, then every REPEAT_CYCLES
    always_comb begin
      hold_cnt_nxt  = '0;
      repeating_nxt = 1'b0;
      repeat_fire_c = 1'b0;
      if (state == HELD && sample) begin
        if ((!repeating && hold_cnt == HOLD_LAST) || (repeating && hold_cnt == REP_LAST)) begin
          repeat_fire_c = 1'b1;
          repeating_nxt = 1'b1;
        end else begin
          hold_cnt_nxt  = hold_cnt + CNT_W'(1);
          repeating_nxt = repeating;
        end
      end
    end

    always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
      end else begin
        hold_cnt  <= hold_cnt_nxt;
        repeating <= repeating_nxt;
      end
    end
`else
    assign repeat_fire_c = 1'b0;
`endif

    // Debounce FSM next-state and strobe generation
    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      down_nxt    = down_q;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
        RELEASED: begin
          cnt_nxt = '0;
          if (sample) begin
            state_nxt = PRESS_PEND;
            cnt_nxt   = CNT_W'(1);
          end
        end
        PRESS_PEND: begin
          if (!sample) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else if (cnt == DB_LAST) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
            down_nxt  = 1'b1;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        HELD: begin
          cnt_nxt = '0;
          if (!sample) begin
            state_nxt = RELEASE_PEND;
            cnt_nxt   = CNT_W'(1);
          end else begin
            press_nxt = repeat_fire_c;
          end
        end
        RELEASE_PEND: begin
          if (sample) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt == DB_LAST) begin
            state_nxt   = RELEASED;
            cnt_nxt     = '0;
            down_nxt    = 1'b0;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
          down_nxt  = 1'b0;
        end
      endcase
    end

    always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
        state     <= RELEASED;
        cnt       <= '0;
        down_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        down_q    <= down_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    assign Key_Down[k]    = down_q;
    assign Key_Press[k]   = press_q;
    assign Key_Release[k] = release_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed bench for key_debouncer with short timing
// parameters (DEBOUNCE=8, HOLD=20, REPEAT=5, 3 keys). Expected edges are
// counted from the first rising edge after KEY changes (edge 1).

module tb_key_debouncer;

  localparam int unsigned NK = 3;

  logic          CLOCK_50;
  logic          Reset;
  logic [NK-1:0] KEY;
  logic [NK-1:0] Key_Down;
  logic [NK-1:0] Key_Press;
  logic [NK-1:0] Key_Release;

  int n_checks = 0;
  int n_pass   = 0;
  int both_err = 0;

  key_debouncer #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (5)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .Reset      (Reset),
    .KEY        (KEY),
    .Key_Down   (Key_Down),
    .Key_Press  (Key_Press),
    .Key_Release(Key_Release)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge and sample 1 ns later
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    if ((Key_Press & Key_Release) != '0) both_err++;
  endtask

  initial begin
    int first_rel;
    int n_rel;
    int bad;
    int first_down;
    int first_press;
    logic [NK-1:0] press_e10;
    logic [NK-1:0] rel_e10;
    int press_at[16];
    int n_press;
    int exp_press[16];
    int n_exp;

    Reset = 1'b1;
    KEY   = 3'b111;

    // Reset state
    repeat (4) tick();
    check("rst_down", 32'(Key_Down), 0);
    check("rst_press", 32'(Key_Press), 0);
    check("rst_release", 32'(Key_Release), 0);
    Reset = 1'b0;
    repeat (2) tick();
    check("idle_down", 32'(Key_Down), 0);

    // Clean press on KEY[0]: Key_Down rises on edge 10
    KEY = 3'b110;
    bad = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (Key_Down != '0 || Key_Press != '0) bad++;
    end
    check("t1_early", 32'(bad), 0);
    tick();
    check("t1_down", 32'(Key_Down), 32'b001);
    check("t1_press", 32'(Key_Press), 32'b001);
    check("t1_release", 32'(Key_Release), 0);
    tick();
    check("t1_press_once", 32'(Key_Press), 0);
    check("t1_down_hold", 32'(Key_Down), 32'b001);

    // KEY[1] bouncing every 3 cycles never gets accepted
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      KEY[1] = (((c / 3) % 2) == 0) ? 1'b0 : 1'b1;
      tick();
      if (Key_Down[1] || Key_Press[1] || Key_Release[1]) bad++;
    end
    KEY[1] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (Key_Down[1] || Key_Press[1] || Key_Release[1]) bad++;
    end
    check("t2_bounce", 32'(bad), 0);
    check("t2_k0_down", 32'(Key_Down), 32'b001);

    // KEY[0] release with a one-cycle glitch after edge 4: release on edge 15
    KEY[0] = 1'b1;
    first_rel = 0;
    n_rel = 0;
    for (int r = 1; r <= 20; r++) begin
      tick();
      if (Key_Release[0]) begin
        n_rel++;
        if (first_rel == 0) first_rel = r;
      end
      if (r == 4) KEY[0] = 1'b0;
      if (r == 5) KEY[0] = 1'b1;
    end
    check("t3_rel_edge", 32'(first_rel), 15);
    check("t3_rel_count", 32'(n_rel), 1);
    check("t3_down", 32'(Key_Down), 0);

    // KEY[0] and KEY[2] pressed together
    repeat (3) tick();
    KEY = 3'b010;
    press_e10 = '0;
    bad = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 10) press_e10 = Key_Press;
      else if (Key_Press != '0) bad++;
    end
    check("t4_press_e10", 32'(press_e10), 32'b101);
    check("t4_press_other", 32'(bad), 0);
    check("t4_down", 32'(Key_Down), 32'b101);
    KEY = 3'b111;
    rel_e10 = '0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 10) rel_e10 = Key_Release;
    end
    check("t4_release_e10", 32'(rel_e10), 32'b101);
    check("t4_down_off", 32'(Key_Down), 0);

    // KEY[1] held through a one-cycle reset pulse
    KEY = 3'b101;
    repeat (12) tick();
    check("t5_down_before", 32'(Key_Down), 32'b010);
    Reset = 1'b1;
    tick();
    check("t5_rst_down", 32'(Key_Down), 0);
    check("t5_rst_release", 32'(Key_Release), 0);
    Reset = 1'b0;
    first_down = 0;
    first_press = 0;
    bad = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (Key_Down[1] && first_down == 0) first_down = e;
      if (Key_Press[1] && first_press == 0) first_press = e;
      if (Key_Release != '0) bad++;
    end
    check("t5_down_edge", 32'(first_down), 10);
    check("t5_press_edge", 32'(first_press), 10);
    check("t5_no_release", 32'(bad), 0);

    // KEY[2] held 60 cycles, then released
    KEY = 3'b111;
    repeat (12) tick();
    KEY = 3'b011;
    n_press = 0;
    first_rel = 0;
    for (int e = 1; e <= 75; e++) begin
      tick();
      if (e == 60) KEY = 3'b111;
      if (Key_Press[2]) begin
        if (n_press < 16) press_at[n_press] = e;
        n_press++;
      end
      if (Key_Release[2] && first_rel == 0) first_rel = e;
    end
    exp_press[0] = 10;
`ifdef KEY_REPEAT_EN
    n_exp = 8;
    for (int i = 1; i < 8; i++) exp_press[i] = 25 + 5 * i;
`else
    n_exp = 1;
`endif
    check("t6_press_count", 32'(n_press), 32'(n_exp));
    for (int i = 0; i < n_exp && i < n_press && i < 16; i++)
      check($sformatf("t6_press_edge%0d", i), 32'(press_at[i]), 32'(exp_press[i]));
    check("t6_release_edge", 32'(first_rel), 70);

    check("press_release_exclusive", 32'(both_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
